// File: rtl/arith_multicycle_ctrl.sv
// arith_multicycle_ctrl: multi-cycle fetch/decode/exec/writeback sequencer for the MIPS arithmetic datapath
module arith_multicycle_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 run,
    output logic                 imem_req,
    output logic [31:0]          imem_addr,
    input  logic                 imem_ack,
    input  logic [31:0]          imem_data,
    output logic [31:0]          inst,
    input  logic                 dec_writeenable,
    input  logic                 dec_except,
    output logic                 alu_res_en,
    output logic                 rf_wr_en,
    output logic                 halted,
    output logic                 exc_flag,
    output logic [31:0]          exc_pc,
    output logic [CNT_WIDTH-1:0] retired,
    output logic [2:0]           state
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, EXC} st_t;
    st_t st, nxt;
    logic [31:0] pc;
    always_comb
        nxt = st == IDLE   ? (run ? FETCH : IDLE) :
              st == FETCH  ? (imem_ack ? DECODE : FETCH) :
              st == DECODE ? (dec_except ? EXC : EXEC) :
              st == EXEC   ? WB :
              st == WB     ? (run ? FETCH : IDLE) :
              st == EXC    ? EXC : IDLE;
    always_ff @(posedge clock) begin
        if (reset) begin
            st         <= IDLE;
            pc         <= RESET_PC;
            inst       <= '0;
            exc_flag   <= 1'b0;
            exc_pc     <= '0;
            retired    <= '0;
            imem_req   <= 1'b0;
            alu_res_en <= 1'b0;
            halted     <= 1'b1;
        end else begin
            st         <= nxt;
            imem_req   <= nxt == FETCH;
            alu_res_en <= nxt == EXEC;
            halted     <= nxt == IDLE || nxt == EXC;
            if (st == FETCH && imem_ack) inst <= imem_data;
            if (st == DECODE && dec_except) begin
                exc_pc   <= pc;
                exc_flag <= 1'b1;
            end
            if (st == WB) begin
                pc <= pc + 32'd4;
                if (~&retired) retired <= retired + 1'b1;
            end
        end
    end
    assign rf_wr_en  = st == WB && dec_writeenable;
    assign imem_addr = pc;
    assign state     = st;
endmodule

// File: tb/tb_arith_multicycle_ctrl.sv
// tb_arith_multicycle_ctrl: scoreboard-driven bench for the multi-cycle sequencer
module tb_arith_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1, rst2 = 1'b1, run = 1'b0, imem_ack = 1'b0;
    logic [31:0] imem_data = '0;
    logic        imem_req, alu_res_en, rf_wr_en, halted, exc_flag;
    logic [31:0] imem_addr, inst, exc_pc;
    logic [15:0] retired;
    logic [2:0]  state;
    logic        dec_we, dec_ex;
    logic        s_req, s_alu, s_rf, s_halted, s_exc, s_we, s_ex;
    logic [31:0] s_addr, s_inst, s_exc_pc;
    logic [1:0]  s_retired;
    logic [2:0]  s_state;
    int          checks = 0, errors = 0;
    typedef struct { logic [31:0] pc; logic we; } exp_t;
    exp_t sb[$];

    localparam logic [31:0] ADD1 = 32'h0022_1820;
    localparam logic [31:0] ADD2 = 32'h0085_1020;
    localparam logic [31:0] BAD  = 32'hFC00_0000;

    // reference decoder: R-type writes, opcode 0x3f faults
    assign dec_we = inst[31:26] == 6'h00;
    assign dec_ex = inst[31:26] == 6'h3f;
    assign s_we   = s_inst[31:26] == 6'h00;
    assign s_ex   = s_inst[31:26] == 6'h3f;

    always #5 clk = ~clk;

    arith_multicycle_ctrl u_dut (
        .clock(clk), .reset(reset), .run(run), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .inst(inst), .dec_writeenable(dec_we),
        .dec_except(dec_ex), .alu_res_en(alu_res_en), .rf_wr_en(rf_wr_en), .halted(halted),
        .exc_flag(exc_flag), .exc_pc(exc_pc), .retired(retired), .state(state)
    );

    arith_multicycle_ctrl #(.RESET_PC(32'hFFFF_FFFC), .CNT_WIDTH(2)) u_small (
        .clock(clk), .reset(rst2), .run(run), .imem_req(s_req), .imem_addr(s_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .inst(s_inst), .dec_writeenable(s_we),
        .dec_except(s_ex), .alu_res_en(s_alu), .rf_wr_en(s_rf), .halted(s_halted),
        .exc_flag(s_exc), .exc_pc(s_exc_pc), .retired(s_retired), .state(s_state)
    );

    // scoreboard: push on an accepted fetch, pop and compare at writeback
    always @(negedge clk) begin
        if (reset) sb.delete();
        else if (state == 3'd1 && imem_ack && imem_data[31:26] != 6'h3f)
            sb.push_back('{pc: imem_addr, we: imem_data[31:26] == 6'h00});
        else if (state == 3'd4) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: writeback at pc %h with nothing expected", imem_addr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (imem_addr !== e.pc || rf_wr_en !== e.we) begin
                    errors++;
                    $display("FAIL wb_check: pc %h rf_wr_en %b, expected pc %h rf_wr_en %b",
                             imem_addr, rf_wr_en, e.pc, e.we);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++;
        if ({state, imem_addr, inst, halted, imem_req, alu_res_en, rf_wr_en, exc_flag, exc_pc, retired} !==
            {3'd0, 32'h0040_0000, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0}) begin
            errors++;
            $display("FAIL reset: state %0d addr %h inst %h halted %b req %b retired %0d",
                     state, imem_addr, inst, halted, imem_req, retired);
        end
    endtask

    task automatic test_basic();
        run = 1'b1; imem_ack = 1'b1; imem_data = ADD1;
        step();
        checks++;
        if (state !== 3'd1 || imem_req !== 1'b1 || imem_addr !== 32'h0040_0000 || halted !== 1'b0) begin
            errors++;
            $display("FAIL basic_fetch: state %0d req %b addr %h halted %b", state, imem_req, imem_addr, halted);
        end
        step();
        imem_ack = 1'b0;
        checks++;
        if (state !== 3'd2 || inst !== ADD1 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL basic_decode: state %0d inst %h req %b", state, inst, imem_req);
        end
        step();
        checks++;
        if (state !== 3'd3 || alu_res_en !== 1'b1 || rf_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL basic_exec: state %0d alu %b rf %b", state, alu_res_en, rf_wr_en);
        end
        step();
        run = 1'b0;
        checks++;
        if (state !== 3'd4 || alu_res_en !== 1'b0 || rf_wr_en !== 1'b1) begin
            errors++;
            $display("FAIL basic_wb: state %0d alu %b rf %b", state, alu_res_en, rf_wr_en);
        end
        step();
        checks++;
        if (state !== 3'd0 || imem_addr !== 32'h0040_0004 || retired !== 16'd1 || halted !== 1'b1) begin
            errors++;
            $display("FAIL basic_retire: state %0d addr %h retired %0d halted %b", state, imem_addr, retired, halted);
        end
    endtask

    task automatic test_delayed_ack();
        run = 1'b1; imem_ack = 1'b0; imem_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (state !== 3'd1 || imem_req !== 1'b1 || imem_addr !== 32'h0040_0004 || inst !== ADD1) begin
                errors++;
                $display("FAIL wait_fetch%0d: state %0d req %b addr %h inst %h", i, state, imem_req, imem_addr, inst);
            end
        end
        imem_ack = 1'b1; imem_data = ADD2;
        step();
        imem_data = 32'hFFFF_FFFF;
        checks++;
        if (state !== 3'd2 || inst !== ADD2) begin
            errors++;
            $display("FAIL wait_capture: state %0d inst %h, expected 2 %h", state, inst, ADD2);
        end
        step();
        step();
        imem_ack = 1'b0;
        checks++;
        if (state !== 3'd4 || inst !== ADD2) begin
            errors++;
            $display("FAIL stray_ack: state %0d inst %h, expected 4 %h", state, inst, ADD2);
        end
        step();
        checks++;
        if (state !== 3'd1 || imem_addr !== 32'h0040_0008 || retired !== 16'd2) begin
            errors++;
            $display("FAIL b2b_fetch: state %0d addr %h retired %0d", state, imem_addr, retired);
        end
    endtask

    task automatic test_exception();
        imem_ack = 1'b1; imem_data = BAD;
        step();
        imem_ack = 1'b0;
        step();
        checks++;
        if (state !== 3'd5 || exc_flag !== 1'b1 || exc_pc !== 32'h0040_0008 || halted !== 1'b1 || alu_res_en !== 1'b0) begin
            errors++;
            $display("FAIL exc_entry: state %0d flag %b exc_pc %h halted %b alu %b", state, exc_flag, exc_pc, halted, alu_res_en);
        end
        for (int i = 0; i < 4; i++) begin
            run = i[0];
            imem_ack = 1'b1;
            step();
            checks++;
            if (state !== 3'd5 || imem_req !== 1'b0 || alu_res_en !== 1'b0 || rf_wr_en !== 1'b0 ||
                retired !== 16'd2 || imem_addr !== 32'h0040_0008 || exc_flag !== 1'b1) begin
                errors++;
                $display("FAIL exc_hold%0d: state %0d req %b alu %b rf %b retired %0d addr %h",
                         i, state, imem_req, alu_res_en, rf_wr_en, retired, imem_addr);
            end
        end
        imem_ack = 1'b0;
        run = 1'b0;
    endtask

    task automatic test_run_drop();
        test_reset();
        run = 1'b1; imem_ack = 1'b1; imem_data = ADD1;
        step();
        step();
        imem_ack = 1'b0;
        step();
        run = 1'b0;
        step();
        step();
        checks++;
        if (state !== 3'd0 || imem_addr !== 32'h0040_0004 || retired !== 16'd1) begin
            errors++;
            $display("FAIL run_drop: state %0d addr %h retired %0d", state, imem_addr, retired);
        end
        step();
        run = 1'b1;
        step();
        checks++;
        if (state !== 3'd1 || imem_addr !== 32'h0040_0004) begin
            errors++;
            $display("FAIL resume: state %0d addr %h, expected 1 00400004", state, imem_addr);
        end
    endtask

    task automatic test_reset_mid();
        imem_ack = 1'b1; imem_data = ADD2;
        step();
        imem_ack = 1'b0;
        step();
        reset = 1'b1;
        step();
        checks++;
        if (state !== 3'd0 || imem_addr !== 32'h0040_0000 || retired !== 16'd0 || rf_wr_en !== 1'b0 || inst !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: state %0d addr %h retired %0d rf %b inst %h", state, imem_addr, retired, rf_wr_en, inst);
        end
        run = 1'b0;
    endtask

    task automatic test_saturation();
        logic [1:0] exp_ret[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        rst2 = 1'b1;
        step();
        rst2 = 1'b0;
        run = 1'b1; imem_ack = 1'b1; imem_data = ADD1;
        for (int i = 0; i < 5; i++) begin
            int n = 0;
            while (s_state !== 3'd4 && n < 12) begin
                step();
                n++;
            end
            step();
            checks++;
            if (n >= 12 || s_retired !== exp_ret[i] || s_addr !== 32'(4 * i)) begin
                errors++;
                $display("FAIL sat%0d: retired %0d addr %h waited %0d, expected %0d %h",
                         i, s_retired, s_addr, n, exp_ret[i], 32'(4 * i));
            end
        end
        run = 1'b0; imem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_delayed_ack();
        test_exception();
        test_run_drop();
        test_reset_mid();
        test_saturation();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
